// File: rtl/gcd_job_queue_pkg.sv
// rtl/gcd_job_queue_pkg.sv - shared types and widths for the GCD job queue
package gcd_job_queue_pkg;

    localparam int GCD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        STORE
    } gcd_q_state_t;

    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_job_queue_if.sv
// rtl/gcd_job_queue_if.sv - host push/pop and GCD core handshake bundle
interface gcd_job_queue_if;
    import gcd_job_queue_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [GCD_W-1:0] wr_a;
    logic [GCD_W-1:0] wr_b;
    logic             core_start;
    logic [GCD_W-1:0] core_dataa;
    logic [GCD_W-1:0] core_datab;
    logic             core_done;
    logic [GCD_W-1:0] core_result;
    logic             rd_valid;
    logic             rd_ready;
    logic [GCD_W-1:0] rd_data;

    // Environment side: host producer/consumer plus the GCD core.
    modport master (
        output wr_valid, wr_a, wr_b, rd_ready, core_done, core_result,
        input  wr_ready, rd_valid, rd_data, core_start, core_dataa, core_datab
    );

    // Queue side.
    modport slave (
        input  wr_valid, wr_a, wr_b, rd_ready, core_done, core_result,
        output wr_ready, rd_valid, rd_data, core_start, core_dataa, core_datab
    );
endinterface

// File: rtl/gcd_job_queue_fifo.sv
// rtl/gcd_job_queue_fifo.sv - first-word-fall-through FIFO with clock enable
module gcd_job_queue_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = clk_en && push && !full;
    assign do_pop  = clk_en && pop && !empty;
    // Head word is forced to zero while empty so the output is defined from reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only observable once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/gcd_job_queue.sv
// rtl/gcd_job_queue.sv - buffers operand pairs, sequences them through the GCD core
module gcd_job_queue
    import gcd_job_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    gcd_job_queue_if.slave  bus,
    output logic            busy,
    output logic            timeout_err,
    output logic [15:0]     jobs_done
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    gcd_q_state_t     state;
    gcd_pair_t        in_wpair;
    gcd_pair_t        in_rpair;
    logic             in_full;
    logic             in_empty;
    logic             out_full;
    logic             out_empty;
    logic             issue_ok;
    logic             start_q;
    logic [GCD_W-1:0] a_q;
    logic [GCD_W-1:0] b_q;
    logic [GCD_W-1:0] res_q;
    logic [TW-1:0]    tcnt;

    assign in_wpair = '{a: bus.wr_a, b: bus.wr_b};
    // Only one job is ever in flight, so a non-full output FIFO guarantees room at STORE.
    assign issue_ok = (state == IDLE) && !in_empty && !out_full;

    gcd_job_queue_fifo #(.WIDTH($bits(gcd_pair_t)), .DEPTH(DEPTH)) u_in_fifo (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .push   (bus.wr_valid),
        .wdata  (in_wpair),
        .pop    (issue_ok),
        .rdata  (in_rpair),
        .full   (in_full),
        .empty  (in_empty)
    );

    gcd_job_queue_fifo #(.WIDTH(GCD_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .push   (state == STORE),
        .wdata  (res_q),
        .pop    (bus.rd_ready),
        .rdata  (bus.rd_data),
        .full   (out_full),
        .empty  (out_empty)
    );

    assign bus.wr_ready   = !in_full;
    assign bus.rd_valid   = !out_empty;
    assign bus.core_start = start_q;
    assign bus.core_dataa = a_q;
    assign bus.core_datab = b_q;
    assign busy           = (state != IDLE) || !in_empty;

    // Job sequencer: issue, wait for done to fall then rise, store the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
            jobs_done   <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        a_q     <= in_rpair.a;
                        b_q     <= in_rpair.b;
                        start_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    tcnt    <= '0;
                    state   <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!bus.core_done) begin
                        state <= WAIT_HI;
                    end else if (tcnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (bus.core_done) begin
                        res_q <= bus.core_result;
                        state <= STORE;
                    end
                end
                STORE: begin
                    jobs_done <= jobs_done + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
